// File: rtl/led_pwm_multi_if.sv
// Configuration write channel for led_pwm_multi: valid/ready write handshake plus
// the one-cycle error pulse for writes to a non-existent channel.
interface led_pwm_multi_if #(
    parameter int NUM_CH     = 4,
    parameter int PWM_WIDTH  = 8,
    parameter int RATE_WIDTH = 8
);
    localparam int CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [CH_AW-1:0]      cfg_ch;
    logic [1:0]            cfg_mode;
    logic [PWM_WIDTH-1:0]  cfg_duty;
    logic [RATE_WIDTH-1:0] cfg_rate;
    logic                  cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/led_pwm_multi.sv
// Multi-channel LED PWM controller (OFF/ON/STATIC/BREATHE) with frame-aligned config apply.
// Define LED_PWM_GAMMA_EN to square the effective duty, g(d) = (d*d)>>W, before the compare.
module led_pwm_multi #(
    parameter int NUM_CH       = 4,
    parameter int PWM_WIDTH    = 8,
    parameter int PWM_PRESCALE = 16,
    parameter int RATE_WIDTH   = 8
) (
    input  logic              in_clk,
    input  logic              in_rst,
    led_pwm_multi_if.slave    cfg,
    output logic              frame_sync,
    output logic [NUM_CH-1:0] out_led
);
    localparam int CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PS_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PWM_WIDTH-1:0] MAX = '1;

    typedef enum logic [1:0] {M_OFF, M_ON, M_STATIC, M_BREATHE} mode_t;

    logic [PS_W-1:0]      presc;
    logic [PWM_WIDTH-1:0] pwm_ctr;
    logic                 tick, frame_end, wr_ok;
    logic [CH_AW-1:0]     wr_ch;
    logic [NUM_CH-1:0]    wr_hit, pend;

    mode_t                 sh_mode  [NUM_CH];
    logic [PWM_WIDTH-1:0]  sh_duty  [NUM_CH];
    logic [RATE_WIDTH-1:0] sh_rate  [NUM_CH];
    mode_t                 act_mode [NUM_CH];
    logic [PWM_WIDTH-1:0]  act_duty [NUM_CH];
    logic [RATE_WIDTH-1:0] act_rate [NUM_CH];
    logic [PWM_WIDTH-1:0]  level    [NUM_CH];
    logic                  dir_dn   [NUM_CH];
    logic [RATE_WIDTH-1:0] step_ctr [NUM_CH];
    logic [PWM_WIDTH-1:0]  d_lat    [NUM_CH];

    mode_t                 n_mode   [NUM_CH];
    logic [PWM_WIDTH-1:0]  n_duty   [NUM_CH];
    logic [RATE_WIDTH-1:0] n_rate   [NUM_CH];
    logic [PWM_WIDTH-1:0]  n_level  [NUM_CH];
    logic                  n_dn     [NUM_CH];
    logic [RATE_WIDTH-1:0] n_step   [NUM_CH];
    logic [PWM_WIDTH-1:0]  n_d      [NUM_CH];

    function automatic logic [PWM_WIDTH-1:0] eff_duty(input mode_t m,
                                                      input logic [PWM_WIDTH-1:0] duty,
                                                      input logic [PWM_WIDTH-1:0] lvl);
        case (m)
            M_OFF:    eff_duty = '0;
            M_ON:     eff_duty = MAX;
            M_STATIC: eff_duty = duty;
            default:  eff_duty = lvl;
        endcase
    endfunction

    function automatic logic [PWM_WIDTH-1:0] shape(input logic [PWM_WIDTH-1:0] d);
`ifdef LED_PWM_GAMMA_EN
        logic [2*PWM_WIDTH-1:0] sq;
        sq    = {{PWM_WIDTH{1'b0}}, d} * {{PWM_WIDTH{1'b0}}, d};
        shape = (d == MAX) ? MAX : sq[2*PWM_WIDTH-1:PWM_WIDTH];
`else
        shape = d;
`endif
    endfunction

    assign tick      = (presc == PS_W'(PWM_PRESCALE - 1));
    assign frame_end = tick && (pwm_ctr == MAX);
    assign wr_ch     = cfg.cfg_ch;
    assign wr_ok     = cfg.cfg_valid && cfg.cfg_ready &&
                       ({{(32-CH_AW){1'b0}}, wr_ch} < NUM_CH);

    // Next active state per channel, evaluated for use at frame_end only.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]  = wr_ok && (wr_ch == CH_AW'(i));
            n_mode[i]  = act_mode[i];
            n_duty[i]  = act_duty[i];
            n_rate[i]  = act_rate[i];
            n_level[i] = level[i];
            n_dn[i]    = dir_dn[i];
            n_step[i]  = step_ctr[i];
            if (pend[i]) begin
                n_mode[i] = sh_mode[i];
                n_duty[i] = sh_duty[i];
                n_rate[i] = sh_rate[i];
                if (sh_mode[i] == M_BREATHE) begin
                    n_level[i] = '0;
                    n_dn[i]    = 1'b0;
                    n_step[i]  = '0;
                end
            end else if (act_mode[i] == M_BREATHE) begin
                if (step_ctr[i] == act_rate[i]) begin
                    n_step[i] = '0;
                    if (act_duty[i] == '0) begin
                        n_level[i] = '0;
                        n_dn[i]    = 1'b0;
                    end else if (!dir_dn[i]) begin
                        n_level[i] = level[i] + 1'b1;
                        n_dn[i]    = (level[i] + 1'b1 == act_duty[i]);
                    end else begin
                        n_level[i] = level[i] - 1'b1;
                        n_dn[i]    = (level[i] != PWM_WIDTH'(1));
                    end
                end else begin
                    n_step[i] = step_ctr[i] + 1'b1;
                end
            end
            n_d[i] = shape(eff_duty(n_mode[i], n_duty[i], n_level[i]));
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            presc         <= '0;
            pwm_ctr       <= '0;
            frame_sync    <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            cfg.cfg_err   <= 1'b0;
            out_led       <= '0;
            pend          <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_mode[i]  <= M_OFF;
                sh_duty[i]  <= '0;
                sh_rate[i]  <= '0;
                act_mode[i] <= M_OFF;
                act_duty[i] <= '0;
                act_rate[i] <= '0;
                level[i]    <= '0;
                dir_dn[i]   <= 1'b0;
                step_ctr[i] <= '0;
                d_lat[i]    <= '0;
            end
        end else begin
            presc         <= tick ? '0 : presc + 1'b1;
            pwm_ctr       <= tick ? pwm_ctr + 1'b1 : pwm_ctr;
            frame_sync    <= frame_end;
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= cfg.cfg_valid && cfg.cfg_ready && !wr_ok;
            for (int i = 0; i < NUM_CH; i++) begin
                // A write landing on the frame_end edge stays pending for the next frame.
                if (wr_hit[i]) begin
                    sh_mode[i] <= mode_t'(cfg.cfg_mode);
                    sh_duty[i] <= cfg.cfg_duty;
                    sh_rate[i] <= cfg.cfg_rate;
                    pend[i]    <= 1'b1;
                end else if (frame_end) begin
                    pend[i] <= 1'b0;
                end
                if (frame_end) begin
                    act_mode[i] <= n_mode[i];
                    act_duty[i] <= n_duty[i];
                    act_rate[i] <= n_rate[i];
                    level[i]    <= n_level[i];
                    dir_dn[i]   <= n_dn[i];
                    step_ctr[i] <= n_step[i];
                    d_lat[i]    <= n_d[i];
                end
                out_led[i] <= (d_lat[i] == '0)  ? 1'b0 :
                              (d_lat[i] == MAX) ? 1'b1 : (pwm_ctr < d_lat[i]);
            end
        end
    end
endmodule

// File: tb/tb_led_pwm_multi.sv
// Scoreboard bench for led_pwm_multi: per-frame high-cycle counts per channel are
// predicted from a behavioural model and compared at every frame_sync.
module tb_led_pwm_multi;
    localparam int NCH   = 4;
    localparam int PS    = 2;
    localparam int FRAME = 256 * PS;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           frame_sync, frame_sync2;
    logic [NCH-1:0] led;
    logic [4:0]     led2;

    always #5 clk = ~clk;

    led_pwm_multi_if #(.NUM_CH(NCH), .PWM_WIDTH(8), .RATE_WIDTH(8)) cif ();
    led_pwm_multi_if #(.NUM_CH(5),   .PWM_WIDTH(8), .RATE_WIDTH(8)) cif2 ();

    led_pwm_multi #(.NUM_CH(NCH), .PWM_WIDTH(8), .PWM_PRESCALE(PS), .RATE_WIDTH(8)) dut (
        .in_clk(clk), .in_rst(rst), .cfg(cif), .frame_sync(frame_sync), .out_led(led));

    led_pwm_multi #(.NUM_CH(5), .PWM_WIDTH(8), .PWM_PRESCALE(PS), .RATE_WIDTH(8)) dut2 (
        .in_clk(clk), .in_rst(rst), .cfg(cif2), .frame_sync(frame_sync2), .out_led(led2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: active and shadow config, frames since last apply.
    int m_mode[NCH], m_duty[NCH], m_rate[NCH], m_brk[NCH];
    int s_mode[NCH], s_duty[NCH], s_rate[NCH];
    bit s_pend[NCH];
    int exp_q[$];

    function automatic int gam(input int d);
`ifdef LED_PWM_GAMMA_EN
        return (d == 255) ? 255 : (d * d) / 256;
`else
        return d;
`endif
    endfunction

    function automatic int level_of(input int duty, input int rate, input int brk);
        int s, p;
        if (duty == 0) return 0;
        s = brk / (rate + 1);
        p = s % (2 * duty);
        return (p <= duty) ? p : 2 * duty - p;
    endfunction

    function automatic int exp_clk(input int ch);
        int d, g;
        case (m_mode[ch])
            0:       d = 0;
            1:       d = 255;
            2:       d = m_duty[ch];
            default: d = level_of(m_duty[ch], m_rate[ch], m_brk[ch]);
        endcase
        g = gam(d);
        return (g == 0) ? 0 : (g == 255) ? FRAME : PS * g;
    endfunction

    task automatic push_frame();
        for (int c = 0; c < NCH; c++) exp_q.push_back(exp_clk(c));
        for (int c = 0; c < NCH; c++) begin
            if (s_pend[c]) begin
                m_mode[c] = s_mode[c]; m_duty[c] = s_duty[c]; m_rate[c] = s_rate[c];
                m_brk[c]  = 0;         s_pend[c] = 1'b0;
            end else begin
                m_brk[c]++;
            end
        end
    endtask

    task automatic mw(input int ch, input int mode, input int duty, input int rate);
        s_mode[ch] = mode; s_duty[ch] = duty; s_rate[ch] = rate; s_pend[ch] = 1'b1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_duty[c] = 0; m_rate[c] = 0; m_brk[c] = 0; s_pend[c] = 1'b0;
        end
    endtask

    task automatic wr(input int ch, input int mode, input int duty, input int rate);
        cif.cfg_valid = 1'b1;
        cif.cfg_ch    = 2'(ch);
        cif.cfg_mode  = 2'(mode);
        cif.cfg_duty  = 8'(duty);
        cif.cfg_rate  = 8'(rate);
        @(negedge clk);
        cif.cfg_valid = 1'b0;
    endtask

    task automatic wr2(input int ch, input int mode, input logic exp_err);
        cif2.cfg_valid = 1'b1;
        cif2.cfg_ch    = 3'(ch);
        cif2.cfg_mode  = 2'(mode);
        cif2.cfg_duty  = 8'd0;
        cif2.cfg_rate  = 8'd0;
        @(negedge clk);
        cif2.cfg_valid = 1'b0;
        check($sformatf("err_pulse_ch%0d", ch), cif2.cfg_err, exp_err);
        @(negedge clk);
        check($sformatf("err_clear_ch%0d", ch), cif2.cfg_err, 1'b0);
    endtask

    task automatic wait_sync(input int n);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!frame_sync && t < FRAME + 8);
            if (!frame_sync) check("frame_sync_timeout", 0, 1);
        end
        #1;
    endtask

    // Count high cycles of each channel over one frame window, closing at frame_sync.
    int cnt[NCH];
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) cnt[i] = 0;
        end else begin
            for (int i = 0; i < NCH; i++) cnt[i] += int'(led[i]);
            if (frame_sync) begin
                if (exp_q.size() >= NCH)
                    for (int i = 0; i < NCH; i++)
                        check($sformatf("frame_ch%0d", i), cnt[i], exp_q.pop_front());
                for (int i = 0; i < NCH; i++) cnt[i] = 0;
            end
        end
    end

    initial begin
        #(400_000 * 10);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cif.cfg_valid  = 1'b0; cif.cfg_ch  = '0; cif.cfg_mode  = '0; cif.cfg_duty  = '0; cif.cfg_rate  = '0;
        cif2.cfg_valid = 1'b0; cif2.cfg_ch = '0; cif2.cfg_mode = '0; cif2.cfg_duty = '0; cif2.cfg_rate = '0;
        model_reset();

        repeat (10) @(negedge clk);
        check("rst_led", led, 0);
        check("rst_ready", cif.cfg_ready, 0);
        check("rst_err", cif.cfg_err, 0);
        check("rst_sync", frame_sync, 0);
        rst = 1'b0;
        #1 check("ready_before_edge", cif.cfg_ready, 0);
        @(posedge clk);
        #1 check("ready_after_edge", cif.cfg_ready, 1);
        @(negedge clk);

        // Out-of-range channel writes on the 5-channel instance; ch4 is the last legal one.
        wr2(5, 1, 1'b1);
        wr2(7, 1, 1'b1);
        wr2(4, 1, 1'b0);
        wr2(0, 1, 1'b0);

        wait_sync(1);

        // STATIC, ON and a short BREATHE triangle.
        mw(1, 2, 64, 0);
        mw(3, 1, 0, 0);
        mw(2, 3, 4, 0);
        repeat (11) push_frame();
        wr(1, 2, 64, 0);
        wr(3, 1, 0, 0);
        wr(2, 3, 4, 0);
        wait_sync(11);

        // duty 0 then 255 on ch0, the 255 landing on the frame_end edge; last write wins on ch3.
        mw(0, 2, 0, 0);
        mw(3, 2, 200, 0);
        mw(3, 2, 32, 0);
        push_frame();
        mw(0, 2, 255, 0);
        repeat (2) push_frame();
        wr(0, 2, 0, 0);
        wr(3, 2, 200, 0);
        wr(3, 2, 32, 0);
        repeat (FRAME - 4) @(negedge clk);
        wr(0, 2, 255, 0);
        wait_sync(2);

        // BREATHE with rate 1 (two frames per level) and a mid-range STATIC duty.
        mw(2, 3, 3, 1);
        mw(1, 2, 128, 0);
        repeat (9) push_frame();
        wr(2, 3, 3, 1);
        wr(1, 2, 128, 0);
        wait_sync(9);

        check("dut2_leds", led2, 5'b10001);

        // Reset while breathing: outputs drop without a clock edge, config returns to OFF.
        repeat (100) @(negedge clk);
        wr(1, 1, 0, 0);
        #2 rst = 1'b1;
        #1 check("async_rst_led", led, 0);
        check("async_rst_ready", cif.cfg_ready, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_sync(1);
        repeat (2) push_frame();
        wait_sync(2);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
